fetch_queue: RTL and testbench

Instruction fetch unit with a prefetch buffer. It sits directly upstream of the single-cycle datapath and supplies the instruction word and its PC. It issues word-aligned requests to an instruction memory that has variable latency and in-order responses. It buffers returned words in a small FIFO and, on a control-flow redirect (branch/jump target), flushes the FIFO and discards responses that are still in flight.

---
 rtl/fetch_queue.sv | 117 +++++++++++
 tb/tb_fetch_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small prefetch FIFO.
// Issues word-aligned requests to a variable-latency, in-order instruction
// memory. Returned words are buffered together with their PC. A redirect
// flushes the buffer and marks every in-flight response as stale so it is
// dropped when it arrives.
module fetch_queue #(
    parameter int              PC_W     = 32,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    output logic [PC_W-1:0]  imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [INS_W-1:0] imem_resp_data,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             instr_valid,
    output logic [INS_W-1:0] instr,
    output logic [PC_W-1:0]  instr_pc,
    input  logic             instr_ready
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam logic [CW:0]     CAP      = (CW + 1)'(DEPTH);
    localparam logic [PC_W-1:0] STEP     = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN    = ~PC_W'(3);
    localparam logic [PC_W-1:0] START_PC = RESET_PC & ALIGN;

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  exp_pc;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    drop;
    logic [CW-1:0]    count;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [PC_W-1:0]  pc_mem   [DEPTH];
    logic [INS_W-1:0] word_mem [DEPTH];

    logic            req_fire;
    logic            resp_live;
    logic            resp_keep;
    logic            pop;
    logic [PC_W-1:0] target_pc;

    // Buffered plus outstanding words never exceed DEPTH, so every live
    // response is guaranteed a free FIFO slot when it arrives.
    assign imem_req_valid = !reset && !redirect_valid &&
                            (({1'b0, count} + {1'b0, inflight}) < CAP);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_live      = imem_resp_valid && (inflight != '0);
    assign resp_keep      = resp_live && (drop == '0) && !redirect_valid;

    assign instr_valid    = (count != '0);
    assign pop            = instr_valid && instr_ready;
    assign instr          = word_mem[head];
    assign instr_pc       = pc_mem[head];
    assign target_pc      = redirect_pc & ALIGN;

    // Fetch/expected PCs, outstanding/stale counters and FIFO pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= START_PC;
            exp_pc   <= START_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= target_pc;
            exp_pc   <= target_pc;
            inflight <= inflight - CW'(resp_live);
            drop     <= inflight - CW'(resp_live);
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + STEP;
            end
            inflight <= inflight + CW'(req_fire) - CW'(resp_live);
            if (resp_live && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            if (resp_keep) begin
                exp_pc <= exp_pc + STEP;
                tail   <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            count <= count + CW'(resp_keep) - CW'(pop);
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                word_mem[i] <= '0;
            end
        end else if (resp_keep) begin
            pc_mem[tail]   <= exp_pc;
            word_mem[tail] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized self-checking bench for fetch_queue.
// The bench plays the instruction memory (in-order, variable latency) and
// keeps a queue-based reference model: a list of outstanding requests tagged
// live/stale and a list of buffered {pc, word} entries.
module tb_fetch_queue;

    localparam int          PC_W     = 32;
    localparam int          INS_W    = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic             clk;
    logic             reset;
    logic             imem_req_valid;
    logic [PC_W-1:0]  imem_req_addr;
    logic             imem_req_ready;
    logic             imem_resp_valid;
    logic [INS_W-1:0] imem_resp_data;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             instr_valid;
    logic [INS_W-1:0] instr;
    logic [PC_W-1:0]  instr_pc;
    logic             instr_ready;

    fetch_queue #(
        .PC_W    (PC_W),
        .INS_W   (INS_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    pend_t       pend[$];
    ent_t        fifo[$];
    logic [31:0] m_fetch_pc;
    int          cyc;
    int          last_due;
    int          total;
    int          passed;
    int          lat_min;
    int          lat_max;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic modelReset();
        pend.delete();
        fifo.delete();
        m_fetch_pc = RESET_PC & ~32'h3;
        last_due   = -1;
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the model on the rising edge.
    task automatic applyStimulus(input bit redir, input logic [31:0] rpc,
                                 input bit mem_ready, input bit cons_ready);
        bit    exp_req;
        bit    resp_v;
        bit    exp_pop;
        ent_t  e;
        pend_t p;
        int    due;

        resp_v          = (pend.size() > 0) && (pend[0].due <= cyc);
        redirect_valid  = redir;
        redirect_pc     = rpc;
        imem_req_ready  = mem_ready;
        instr_ready     = cons_ready;
        imem_resp_valid = resp_v;
        imem_resp_data  = resp_v ? memWord(pend[0].addr) : $urandom();
        exp_req         = !redir && ((fifo.size() + pend.size()) < DEPTH);
        #1;
        checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) begin
            checkOutput("req_addr", imem_req_addr, m_fetch_pc);
        end
        checkOutput("instr_valid", 32'(instr_valid), 32'(fifo.size() > 0));
        if (fifo.size() > 0) begin
            checkOutput("instr_pc", instr_pc, fifo[0].pc);
            checkOutput("instr", instr, fifo[0].word);
        end

        @(posedge clk);
        exp_pop = (fifo.size() > 0) && cons_ready;
        if (exp_pop) begin
            void'(fifo.pop_front());
        end
        if (resp_v) begin
            p = pend.pop_front();
            if (!redir && !p.stale) begin
                e.pc   = p.addr;
                e.word = memWord(p.addr);
                fifo.push_back(e);
            end
        end
        if (redir) begin
            fifo.delete();
            foreach (pend[k]) pend[k].stale = 1'b1;
            m_fetch_pc = rpc & ~32'h3;
        end else if (exp_req && mem_ready) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            p.addr  = m_fetch_pc;
            p.stale = 1'b0;
            p.due   = due;
            pend.push_back(p);
            last_due   = due;
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Asserts reset between clock edges and checks the immediate effect.
    task automatic asyncReset();
        #2;
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        instr_ready     = 1'b0;
        #1;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_instr_pc", instr_pc, 32'd0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic runRandom(input int n, input int redir_pct, input int ready_pct, input int cons_pct);
        logic [31:0] rpc;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
            else                           rpc = 32'($urandom_range(32'hFFF, 0));
            applyStimulus($urandom_range(99, 0) < redir_pct, rpc,
                          $urandom_range(99, 0) < ready_pct,
                          $urandom_range(99, 0) < cons_pct);
        end
    endtask

    // Directed scenarios followed by a long randomized run.
    initial begin
        total           = 0;
        passed          = 0;
        cyc             = 0;
        lat_min         = 1;
        lat_max         = 1;
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        instr_ready     = 1'b0;
        modelReset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("init_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("init_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("init_instr", instr, 32'd0);
        checkOutput("init_instr_pc", instr_pc, 32'd0);
        reset = 1'b0;

        $display("[TB] straight-line fetch, 1-cycle memory");
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] consumer backpressure then drain");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)  applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] 3-cycle memory, redirect to 0x100 with requests in flight");
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] misaligned redirect target");
        applyStimulus(1'b1, 32'h102, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] redirect with handshake and response in the same cycle");
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] full FIFO then asynchronous reset");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        asyncReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] randomized traffic");
        lat_min = 1;
        lat_max = 4;
        runRandom(2000, 8, 80, 70);
        asyncReset();
        runRandom(2000, 3, 60, 50);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
